// File: rtl/i2c_pkg.sv
// i2c_pkg: shared definitions for the I2C transaction arbiter.
//   - field widths of a posted register transaction
//   - arbiter FSM state type
//   - response error encodings returned with resp_valid
//   - packed transaction record latched at grant time
package i2c_pkg;

  localparam int I2C_ADDR_W = 7;
  localparam int I2C_REG_W  = 8;
  localparam int I2C_DATA_W = 8;
  localparam int I2C_ERR_W  = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_e;

  typedef logic [I2C_ERR_W-1:0] i2c_err_t;

  localparam i2c_err_t I2C_OK      = 2'b00;
  localparam i2c_err_t I2C_NACK    = 2'b01;
  localparam i2c_err_t I2C_TIMEOUT = 2'b10;

  // One requester's transaction; rw = 1 means write.
  typedef struct packed {
    logic [I2C_ADDR_W-1:0] slave_addr;
    logic [I2C_REG_W-1:0]  reg_addr;
    logic [I2C_DATA_W-1:0] wdata;
    logic                  rw;
  } i2c_txn_t;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick.
//   req      - request vector
//   last_gnt - index of the previous winner (held by the parent)
//   gnt      - one-hot grant, all zero when no request is pending
//   gnt_idx  - binary index of gnt (0 when nothing is granted)
// The search starts at last_gnt+1 and wraps, so the previous winner has the
// lowest priority on the next pick.
module rr_arbiter #(
  parameter int N     = 2,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last_gnt,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx
);

  logic found;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    for (int off = 1; off <= N; off++) begin
      int cand;
      cand = int'(last_gnt) + off;
      if (cand >= N) cand = cand - N;
      if (!found && req[cand]) begin
        found      = 1'b1;
        gnt[cand]  = 1'b1;
        gnt_idx    = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/i2c_txn_arbiter.sv
// i2c_txn_arbiter: shares one byte-level I2C master between NUM_REQ
// requesters, one register transaction at a time.
//   clk, reset_n        - clock, asynchronous active-low reset
//   req_*               - per-requester transaction posts (packed fields)
//   req_ready           - one-hot accept pulse
//   resp_valid/rdata/err- one-hot completion pulse with read data and status
//   mst_*               - command/abort towards the master, done/nack/rdata back
//   busy                - high whenever a transaction is in flight
// Every output comes straight from a flop; each pulse is visible while the
// FSM sits in the state that owns it (req_ready in ISSUE, mst_start in the
// first WAIT cycle, resp_valid in RESP).
module i2c_txn_arbiter
  import i2c_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*I2C_ADDR_W-1:0] req_slave_addr,
  input  logic [NUM_REQ*I2C_REG_W-1:0]  req_reg_addr,
  input  logic [NUM_REQ*I2C_DATA_W-1:0] req_wdata,
  input  logic [NUM_REQ-1:0]            req_rw,
  output logic [NUM_REQ-1:0]            resp_valid,
  output logic [I2C_DATA_W-1:0]         resp_rdata,
  output logic [I2C_ERR_W-1:0]          resp_err,
  output logic                          mst_start,
  output logic [I2C_ADDR_W-1:0]         mst_slave_addr,
  output logic [I2C_REG_W-1:0]          mst_reg_addr,
  output logic [I2C_DATA_W-1:0]         mst_wdata,
  output logic                          mst_rw,
  output logic                          mst_abort,
  input  logic                          mst_done,
  input  logic                          mst_nack,
  input  logic [I2C_DATA_W-1:0]         mst_rdata,
  output logic                          busy
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [CNT_W-1:0] CNT_LIMIT    = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [IDX_W-1:0] LAST_GNT_RST = IDX_W'(NUM_REQ - 1);

  // Unpack the per-requester fields into records
  i2c_txn_t req_txn [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign req_txn[gi].slave_addr = req_slave_addr[gi*I2C_ADDR_W +: I2C_ADDR_W];
    assign req_txn[gi].reg_addr   = req_reg_addr[gi*I2C_REG_W +: I2C_REG_W];
    assign req_txn[gi].wdata      = req_wdata[gi*I2C_DATA_W +: I2C_DATA_W];
    assign req_txn[gi].rw         = req_rw[gi];
  end

  // State and registered outputs
  arb_state_e                state_q, state_d;
  logic [IDX_W-1:0]          last_gnt_q, last_gnt_d;
  logic [IDX_W-1:0]          gnt_idx_q, gnt_idx_d;
  i2c_txn_t                  txn_q, txn_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [NUM_REQ-1:0]        req_ready_q, req_ready_d;
  logic [NUM_REQ-1:0]        resp_valid_q, resp_valid_d;
  logic [I2C_DATA_W-1:0]     resp_rdata_q, resp_rdata_d;
  i2c_err_t                  resp_err_q, resp_err_d;
  logic                      mst_start_q, mst_start_d;
  logic                      mst_abort_q, mst_abort_d;
  logic                      busy_q, busy_d;

  logic [NUM_REQ-1:0]        arb_gnt;
  logic [IDX_W-1:0]          arb_idx;
  logic [NUM_REQ-1:0]        gnt_oh;
  logic [CNT_W-1:0]          cnt_inc;

  rr_arbiter #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_rr_arbiter (
    .req      (req_valid),
    .last_gnt (last_gnt_q),
    .gnt      (arb_gnt),
    .gnt_idx  (arb_idx)
  );

  // One-hot of the latched winner, used to steer resp_valid
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_gnt_oh
    assign gnt_oh[gi] = (gnt_idx_q == IDX_W'(gi));
  end

  // Saturating increment: the counter parks at the limit instead of wrapping
  assign cnt_inc = (cnt_q == CNT_LIMIT) ? cnt_q : cnt_q + CNT_W'(1);

  always_comb begin
    state_d      = state_q;
    last_gnt_d   = last_gnt_q;
    gnt_idx_d    = gnt_idx_q;
    txn_d        = txn_q;
    cnt_d        = cnt_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    req_ready_d  = '0;
    resp_valid_d = '0;
    mst_start_d  = 1'b0;
    mst_abort_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (|req_valid) begin
          req_ready_d = arb_gnt;
          gnt_idx_d   = arb_idx;
          last_gnt_d  = arb_idx;
          txn_d       = req_txn[arb_idx];
          state_d     = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        mst_start_d = 1'b1;
        cnt_d       = '0;
        state_d     = ST_WAIT;
      end

      ST_WAIT: begin
        cnt_d = cnt_inc;
        // cnt_q == limit means the abort pulse is already out: the
        // transaction is lost even if the master reports done now.
        if (mst_done && (cnt_q != CNT_LIMIT)) begin
          resp_rdata_d = txn_q.rw ? '0 : mst_rdata;
          resp_err_d   = mst_nack ? I2C_NACK : I2C_OK;
          resp_valid_d = gnt_oh;
          state_d      = ST_RESP;
        end else if (cnt_q == CNT_LIMIT) begin
          resp_rdata_d = '0;
          resp_err_d   = I2C_TIMEOUT;
          resp_valid_d = gnt_oh;
          state_d      = ST_RESP;
        end else if (cnt_inc == CNT_LIMIT) begin
          // Last cycle in which done could still arrive; without it the
          // abort goes out TIMEOUT_CYCLES cycles after mst_start.
          mst_abort_d = 1'b1;
        end
      end

      ST_RESP: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      last_gnt_q   <= LAST_GNT_RST;
      gnt_idx_q    <= '0;
      txn_q        <= '0;
      cnt_q        <= '0;
      req_ready_q  <= '0;
      resp_valid_q <= '0;
      resp_rdata_q <= '0;
      resp_err_q   <= I2C_OK;
      mst_start_q  <= 1'b0;
      mst_abort_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_gnt_q   <= last_gnt_d;
      gnt_idx_q    <= gnt_idx_d;
      txn_q        <= txn_d;
      cnt_q        <= cnt_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
      mst_start_q  <= mst_start_d;
      mst_abort_q  <= mst_abort_d;
      busy_q       <= busy_d;
    end
  end

  assign req_ready      = req_ready_q;
  assign resp_valid     = resp_valid_q;
  assign resp_rdata     = resp_rdata_q;
  assign resp_err       = resp_err_q;
  assign mst_start      = mst_start_q;
  assign mst_abort      = mst_abort_q;
  assign mst_slave_addr = txn_q.slave_addr;
  assign mst_reg_addr   = txn_q.reg_addr;
  assign mst_wdata      = txn_q.wdata;
  assign mst_rw         = txn_q.rw;
  assign busy           = busy_q;

endmodule

// File: tb/tb_i2c_txn_arbiter.sv
// Self-checking bench for i2c_txn_arbiter with a transaction-level model:
// requesters are arrays of posted transactions, the expected winner is the
// first posted requester after the previous winner, and the bench plays the
// I2C master with a chosen response delay (or silence for a timeout).
module tb_i2c_txn_arbiter;

  localparam int N  = 3;
  localparam int TO = 16;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic [N-1:0]     req_valid = '0;
  logic [N-1:0]     req_ready;
  logic [N*7-1:0]   req_slave_addr = '0;
  logic [N*8-1:0]   req_reg_addr = '0;
  logic [N*8-1:0]   req_wdata = '0;
  logic [N-1:0]     req_rw = '0;
  logic [N-1:0]     resp_valid;
  logic [7:0]       resp_rdata;
  logic [1:0]       resp_err;
  logic             mst_start;
  logic [6:0]       mst_slave_addr;
  logic [7:0]       mst_reg_addr;
  logic [7:0]       mst_wdata;
  logic             mst_rw;
  logic             mst_abort;
  logic             mst_done = 1'b0;
  logic             mst_nack = 1'b0;
  logic [7:0]       mst_rdata = '0;
  logic             busy;

  always #5 clk = ~clk;

  i2c_txn_arbiter #(
    .NUM_REQ        (N),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_slave_addr (req_slave_addr),
    .req_reg_addr   (req_reg_addr),
    .req_wdata      (req_wdata),
    .req_rw         (req_rw),
    .resp_valid     (resp_valid),
    .resp_rdata     (resp_rdata),
    .resp_err       (resp_err),
    .mst_start      (mst_start),
    .mst_slave_addr (mst_slave_addr),
    .mst_reg_addr   (mst_reg_addr),
    .mst_wdata      (mst_wdata),
    .mst_rw         (mst_rw),
    .mst_abort      (mst_abort),
    .mst_done       (mst_done),
    .mst_nack       (mst_nack),
    .mst_rdata      (mst_rdata),
    .busy           (busy)
  );

  int errors = 0;
  int checks = 0;
  int txn_no = 0;

  // Model of the posted transactions and the previous winner
  int         last_g;
  bit         mv  [N];
  logic [6:0] msa [N];
  logic [7:0] mra [N];
  logic [7:0] mwd [N];
  bit         mrw [N];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic post(input int i, input logic [6:0] sa, input logic [7:0] ra,
                      input logic [7:0] wd, input bit rw);
    mv[i] = 1'b1; msa[i] = sa; mra[i] = ra; mwd[i] = wd; mrw[i] = rw;
    req_valid[i]             = 1'b1;
    req_slave_addr[7*i +: 7] = sa;
    req_reg_addr[8*i +: 8]   = ra;
    req_wdata[8*i +: 8]      = wd;
    req_rw[i]                = rw;
  endtask

  task automatic post_rand(input int i);
    post(i, 7'($urandom), 8'($urandom), 8'($urandom), 1'($urandom));
  endtask

  task automatic drop(input int i);
    mv[i] = 1'b0;
    req_valid[i] = 1'b0;
  endtask

  // First posted requester after the previous winner, wrapping.
  function automatic int exp_grant();
    for (int off = 1; off <= N; off++) begin
      int c;
      c = (last_g + off) % N;
      if (mv[c]) return c;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] onehot(input int i);
    logic [N-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  // Wait (bounded) for an accept and check it against the model winner.
  task automatic wait_accept(output int g, output bit ok);
    bit found;
    int n;
    g = exp_grant();
    found = 1'b0;
    n = 0;
    while (!found && n < 20) begin
      tick();
      n++;
      if (req_ready != '0) found = 1'b1;
    end
    check("accept_seen", 32'(found), 32'd1);
    ok = found && (g >= 0);
    if (ok) begin
      check("req_ready", 32'(req_ready), 32'(onehot(g)));
      check("busy_accept", 32'(busy), 32'd1);
    end
  endtask

  // One full transaction. k_done < 0: the master stays silent (timeout);
  // otherwise mst_done is driven k_done cycles after mst_start is seen.
  task automatic run_txn(input int k_done, input bit nack, input logic [7:0] rd,
                         input bit repost, input bit stray_done);
    int g, n_wait;
    bit ok;
    logic [6:0] e_sa;
    logic [7:0] e_ra, e_wd, e_rdata;
    bit e_rw;
    logic [1:0] e_err;

    wait_accept(g, ok);
    if (!ok) return;
    e_sa = msa[g]; e_ra = mra[g]; e_wd = mwd[g]; e_rw = mrw[g];
    last_g = g;
    if (repost) post_rand(g);
    else drop(g);
    // A done/nack while the block is not waiting must be ignored
    if (stray_done) begin
      mst_done = 1'b1; mst_nack = 1'b1; mst_rdata = 8'hFF;
    end
    tick();
    mst_done = 1'b0; mst_nack = 1'b0;

    check("mst_start", 32'(mst_start), 32'd1);
    check("req_ready_clr", 32'(req_ready), 32'd0);
    check("mst_slave", 32'(mst_slave_addr), 32'(e_sa));
    check("mst_reg", 32'(mst_reg_addr), 32'(e_ra));
    check("mst_wdata", 32'(mst_wdata), 32'(e_wd));
    check("mst_rw", 32'(mst_rw), 32'(e_rw));

    n_wait = (k_done >= 0) ? k_done + 1 : TO + 1;
    for (int c = 0; c < n_wait; c++) begin
      if (c == 1) check("mst_start_pulse", 32'(mst_start), 32'd0);
      check("mst_abort", 32'(mst_abort), 32'((k_done < 0) && (c == TO)));
      check("resp_early", 32'(resp_valid), 32'd0);
      if (c == k_done) begin
        mst_done = 1'b1; mst_nack = nack; mst_rdata = rd;
      end
      tick();
      mst_done = 1'b0; mst_nack = 1'b0;
    end

    e_err   = (k_done < 0) ? 2'b10 : (nack ? 2'b01 : 2'b00);
    e_rdata = ((k_done < 0) || e_rw) ? 8'h00 : rd;
    check("resp_valid", 32'(resp_valid), 32'(onehot(g)));
    check("resp_err", 32'(resp_err), 32'(e_err));
    check("resp_rdata", 32'(resp_rdata), 32'(e_rdata));
    check("abort_at_resp", 32'(mst_abort), 32'd0);
    check("mst_slave_hold", 32'(mst_slave_addr), 32'(e_sa));
    $display("txn %0d: req=%0d rw=%0d slave=0x%02h reg=0x%02h delay=%0d err=%0d rdata=0x%02h",
             txn_no, g, e_rw, e_sa, e_ra, k_done, resp_err, resp_rdata);
    txn_no++;
    tick();
    check("resp_pulse", 32'(resp_valid), 32'd0);
    check("busy_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    int g, k;
    bit ok;
    last_g = N - 1;
    for (int i = 0; i < N; i++) begin
      mv[i] = 1'b0; msa[i] = '0; mra[i] = '0; mwd[i] = '0; mrw[i] = 1'b0;
    end

    // Reset state
    repeat (3) tick();
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_mst_start", 32'(mst_start), 32'd0);
    check("rst_mst_abort", 32'(mst_abort), 32'd0);
    check("rst_fields", {mst_slave_addr, mst_reg_addr, mst_wdata, mst_rw}, 32'd0);
    reset_n = 1'b1;
    tick();

    // Single write, then a read answered with NACK
    post(0, 7'h50, 8'h10, 8'hA5, 1'b1);
    run_txn(3, 1'b0, 8'hEE, 1'b0, 1'b0);
    post(1, 7'h21, 8'h05, 8'h00, 1'b0);
    run_txn(2, 1'b1, 8'h3C, 1'b0, 1'b1);

    // Round-robin with req0 and req1 held: expected order 0,1,0,1
    post(0, 7'h11, 8'h22, 8'h33, 1'b0);
    post(1, 7'h44, 8'h55, 8'h66, 1'b1);
    for (int i = 0; i < 4; i++) run_txn(i, 1'b0, 8'(8'h80 + i), 1'b1, 1'b0);

    // Timeout, then done arriving in the last cycle before the abort
    run_txn(-1, 1'b0, 8'h00, 1'b1, 1'b0);
    run_txn(TO - 1, 1'b0, 8'h77, 1'b1, 1'b0);

    // Reset in the middle of WAIT
    wait_accept(g, ok);
    if (ok) begin
      drop(g);
      tick();
      check("rw_mst_start", 32'(mst_start), 32'd1);
      repeat (5) tick();
      check("rw_busy", 32'(busy), 32'd1);
      reset_n = 1'b0;
      #1;
      check("rw_busy_rst", 32'(busy), 32'd0);
      check("rw_resp_valid", 32'(resp_valid), 32'd0);
      check("rw_abort", 32'(mst_abort), 32'd0);
      check("rw_resp", {resp_rdata, resp_err}, 32'd0);
      check("rw_fields", {mst_slave_addr, mst_reg_addr, mst_wdata, mst_rw}, 32'd0);
      last_g = N - 1;
      tick();
      reset_n = 1'b1;
      post(0, 7'h2A, 8'h01, 8'h02, 1'b0);
      post(1, 7'h2B, 8'h03, 8'h04, 1'b1);
      run_txn(1, 1'b0, 8'h5A, 1'b0, 1'b0);
    end

    // Randomized traffic
    for (int t = 0; t < 40; t++) begin
      bit any;
      any = 1'b0;
      for (int i = 0; i < N; i++) begin
        if (!mv[i] && ($urandom_range(0, 1) == 1)) post_rand(i);
        any = any | mv[i];
      end
      if (!any) post_rand(int'($urandom_range(0, N - 1)));
      k = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, TO - 1));
      run_txn(k, 1'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/i2c_txn_arbiter.md
# i2c_txn_arbiter

Shares a single byte-level I2C master between `NUM_REQ` independent requesters (sensor pollers, config loaders). Each requester posts one register transaction (slave address, register address, write data, direction). The block picks a requester round-robin, sequences the master through start → completion, enforces a timeout, and returns read data and status to the winning requester. It sits between the system-side clients and the I2C master, so the master never sees concurrent commands.

## Interface
- `NUM_REQ`, 2, number of requesters (2–8)
- `TIMEOUT_CYCLES`, 4096, max `clk` cycles from `mst_start` to `mst_done` before abort
- `clk` in 1 — single clock, all logic on rising edge
- `reset_n` in 1 — asynchronous, active-low reset
- `req_valid` in NUM_REQ — per-requester transaction request; held until accepted
- `req_ready` out NUM_REQ — one-hot, one-cycle accept pulse
- `req_slave_addr` in NUM_REQ*7 — packed 7-bit slave addresses, requester i at [7i+6:7i]
- `req_reg_addr` in NUM_REQ*8 — packed register addresses
- `req_wdata` in NUM_REQ*8 — packed write data
- `req_rw` in NUM_REQ — 1 = write, 0 = read
- `resp_valid` out NUM_REQ — one-hot, one-cycle completion pulse
- `resp_rdata` out 8 — read data, valid with `resp_valid`
- `resp_err` out 2 — 00 OK, 01 NACK, 10 TIMEOUT; valid with `resp_valid`
- `mst_start` out 1 — one-cycle command pulse to master
- `mst_slave_addr` / `mst_reg_addr` / `mst_wdata` out 7/8/8 — latched command fields, stable from `mst_start` until completion
- `mst_rw` out 1 — latched direction
- `mst_abort` out 1 — one-cycle pulse, forces master to STOP/IDLE
- `mst_done` in 1 — one-cycle completion pulse from master
- `mst_nack` in 1 — sampled with `mst_done`; any ACK phase failed
- `mst_rdata` in 8 — sampled with `mst_done`
- `busy` out 1 — high in every state except IDLE

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: if any `req_valid`, grant the first set bit searching upward from `last_gnt+1` (wrapping). In that cycle: pulse `req_ready[g]`, latch the fields of requester g and g itself, set `last_gnt <= g`, then go to ISSUE.
- ISSUE: pulse `mst_start`, clear the timeout counter, go to WAIT.
- WAIT: the counter increments each cycle.
  - `mst_done`: capture `mst_rdata`; set `resp_err` = `mst_nack` ? 01 : 00; go to RESP.
  - Counter reaches `TIMEOUT_CYCLES` with no `mst_done`: pulse `mst_abort`, set `resp_err` = 10, `resp_rdata` = 0, go to RESP.
- RESP: pulse `resp_valid[g]`, return to IDLE.
- Write transactions return `resp_rdata` = 0.
- The counter is `$clog2(TIMEOUT_CYCLES+1)` bits wide and saturates; it never wraps.

## Timing
- Reset values: `req_ready`, `resp_valid`, `mst_start`, `mst_abort`, `busy` = 0. `resp_rdata`, `resp_err`, all `mst_*` fields = 0. State = IDLE. `last_gnt` = NUM_REQ-1, so requester 0 wins first.
- Accept (`req_ready`) → `mst_start`: 1 cycle.
- `mst_done` → `resp_valid`: 1 cycle.
- Earliest next accept: the cycle after RESP. Minimum back-to-back spacing is 4 cycles plus master time.
- `mst_done` in the same cycle the counter hits the limit: `mst_done` wins, no abort.
- `mst_done` or `mst_nack` outside WAIT: ignored.
- `req_valid` dropped after accept: no effect on the transaction in flight.
- `req_valid` changes while not in IDLE: ignored until IDLE.
- `reset_n` low mid-transaction: immediate return to reset values. No `resp_valid` and no `mst_abort` are issued; the master is reset by the same `reset_n`.
- All outputs are registered.

## Structure
- Shared package `i2c_pkg`: FSM state typedef, `resp_err` encodings (`I2C_OK`, `I2C_NACK`, `I2C_TIMEOUT`), address/data width constants.
- Sub-module `rr_arbiter` (param `N`): inputs are the request vector and last-grant index; outputs are a one-hot grant and its index. It is purely combinational; `last_gnt` is held in the parent.

## Test plan
- Single write: req0 valid, slave 0x50, reg 0x10, wdata 0xA5, rw=1; master returns done, nack=0 → `mst_start` 1 cycle after `req_ready[0]` with those fields; `resp_valid[0]`, err 00, rdata 0x00.
- Read with NACK: req1 read, master returns done, nack=1, rdata 0x3C → `resp_valid[1]`, err 01, rdata 0x3C.
- Round-robin: req0 and req1 held continuously, four transactions → grant order 0,1,0,1; no requester granted twice while the other is waiting.
- Timeout: master never responds, TIMEOUT_CYCLES=16 → `mst_abort` pulses 16 cycles after `mst_start`; next cycle `resp_valid` with err 10.
- Done/timeout collision: `mst_done` in the limit cycle → err 00, no `mst_abort`.
- Reset mid-WAIT: deassert `reset_n` → all outputs 0 immediately; after release req0 is granted first.
